cache_mshr: RTL and testbench
=============================

// Module: cache_mshr
// PURPOSE
//  Miss status holding register file that sits downstream of the cache meta next-state stage.
//  Captures each miss allocation, along with the victim write-back it needs.
//  Issues write-back, then read requests to L2 over a valid/ready channel.
//  Returns fills to the data/tag update path when L2 responds.
//  Drives mshr_hit back to the meta stage so that secondary misses to an in-flight line do not re-allocate.
// PARAMETERS
//  N_ENTRIES  4   number of MSHR entries (2..8); entry id width IDW = $clog2(N_ENTRIES)
//  ADDR_W     32  byte address width
//  OFF_W      6   line-offset bits ignored for all address compares (64B lines)
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  alloc_valid    in   1       allocate request (meta-stage mshr_alloc)
//  alloc_addr     in   ADDR_W  missing address
//  alloc_way      in   4       one-hot victim way (meta-stage way_out)
//  alloc_op       in   3       op code: 1=LD, 2=ST
//  alloc_wb       in   1       victim dirty, write-back needed (meta-stage wb_to_l2)
//  alloc_wb_addr  in   ADDR_W  victim line address
//  lookup_addr    in   ADDR_W  address probed by the meta stage
//  mshr_hit       out  1       comb: a valid entry matches lookup_addr[ADDR_W-1:OFF_W]
//  full           out  1       registered: all entries busy
//  overflow       out  1       sticky: alloc_valid seen while full
//  l2_req_valid   out  1       L2 request valid
//  l2_req_ready   in   1       L2 accepts request
//  l2_req_addr    out  ADDR_W  line address, low OFF_W bits forced 0
//  l2_req_wb      out  1       1 = write-back, 0 = read
//  l2_req_id      out  IDW     entry id
//  l2_rsp_valid   in   1       L2 read data returned
//  l2_rsp_id      in   IDW     entry id of the response
//  fill_valid     out  1       one-cycle fill pulse
//  fill_addr      out  ADDR_W  filled line address
//  fill_way       out  4       one-hot way to fill
//  fill_op        out  3       original op, so a ST can merge
// BEHAVIOUR
//  Reset: all entries go to FREE; every output is 0 (full=0, overflow=0, l2_req_valid=0, fill_valid=0).
//  Per-entry FSM: FREE -> (alloc & alloc_wb ? WB_REQ : RD_REQ); WB_REQ -> RD_REQ on accept;
//    RD_REQ -> WAIT on accept; WAIT -> FREE on l2_rsp_valid with matching id.
//  Alloc: takes the lowest-index FREE entry, sampled at the start of the cycle; that entry leaves FREE the next cycle.
//    An entry freed in cycle N is not reallocatable until cycle N+1.
//    Alloc while full: the request is dropped, no state changes, overflow is set (cleared only by reset).
//    Duplicate-line alloc is not merged; upstream gates on mshr_hit.
//  Request arbitration: lowest-index entry in WB_REQ or RD_REQ wins.
//    l2_req_* are registered; once valid=1 they are held stable until ready=1.
//    Accept = valid & ready. The next request may be presented the cycle after an accept.
//  The write-back always issues before the same entry's read (WB_REQ precedes RD_REQ).
//  Response: l2_rsp_valid with an id whose entry is not in WAIT is ignored.
//    A valid response frees the entry and drives fill_* for exactly one cycle, registered: 1-cycle latency after l2_rsp_valid.
//  mshr_hit: combinational OR over non-FREE entries.
//    Compares alloc_addr tags only, not victim addresses.
//    Reflects allocations only from the cycle after they occur.
//  full = 1 when no entry is FREE in the next-state view, so it never lags an allocation.
//  Same-cycle alloc + accept + response on different entries: all three take effect independently.
//  Reset mid-transaction: the async reset clears everything immediately and in-flight ids are lost.
//    L2 must be reset together with this block.
// TESTING
//  1 Reset: rst_n=0 mid-WAIT -> all outputs 0, full=0; the next alloc gets id 0.
//  2 Clean miss: alloc addr=0x1040, way=4'b0100, wb=0, ready=1.
//    -> l2_req addr=0x1040, wb=0, id=0 next cycle; rsp id=0 -> fill_valid 1 cycle later, way=4'b0100.
//  3 Dirty miss: alloc wb=1, wb_addr=0x8000, addr=0x2000.
//    -> request 1 is wb=1 to 0x8000; request 2 is wb=0 to 0x2000; ready held 0 for 3 cycles keeps fields stable.
//  4 Fill N_ENTRIES allocs -> full=1; 5th alloc -> dropped, overflow=1.
//    Response for id 2 -> full=0; next alloc takes id 2.
//  5 mshr_hit: after alloc 0x3000, lookup 0x303F -> 1; lookup 0x3040 -> 0; after fill, lookup 0x3000 -> 0.
//  6 Stray rsp id=3 while entry 3 is FREE -> no fill_valid, no state change.

Source files
------------

// File: rtl/cache_mshr.sv
// Miss status holding registers: tracks outstanding line misses, issues victim write-backs
// and line reads to L2, and returns fills to the data/tag update path.
module cache_mshr #(
    parameter int unsigned N_ENTRIES = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned OFF_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [ADDR_W-1:0]            alloc_addr,
    input  logic [3:0]                   alloc_way,
    input  logic [2:0]                   alloc_op,
    input  logic                         alloc_wb,
    input  logic [ADDR_W-1:0]            alloc_wb_addr,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         mshr_hit,
    output logic                         full,
    output logic                         overflow,
    output logic                         l2_req_valid,
    input  logic                         l2_req_ready,
    output logic [ADDR_W-1:0]            l2_req_addr,
    output logic                         l2_req_wb,
    output logic [$clog2(N_ENTRIES)-1:0] l2_req_id,
    input  logic                         l2_rsp_valid,
    input  logic [$clog2(N_ENTRIES)-1:0] l2_rsp_id,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [3:0]                   fill_way,
    output logic [2:0]                   fill_op
);
    localparam int unsigned IDW   = $clog2(N_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {StFree, StWbReq, StRdReq, StWait} state_e;

    state_e           st_q     [N_ENTRIES];
    state_e           st_d     [N_ENTRIES];
    logic [TAG_W-1:0] tag_q    [N_ENTRIES];
    logic [TAG_W-1:0] tag_d    [N_ENTRIES];
    logic [TAG_W-1:0] wb_tag_q [N_ENTRIES];
    logic [TAG_W-1:0] wb_tag_d [N_ENTRIES];
    logic [3:0]       way_q    [N_ENTRIES];
    logic [3:0]       way_d    [N_ENTRIES];
    logic [2:0]       op_q     [N_ENTRIES];
    logic [2:0]       op_d     [N_ENTRIES];

    logic             full_q, full_d, overflow_q, overflow_d;
    logic             req_valid_q, req_valid_d, req_wb_q, req_wb_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic [IDW-1:0]   req_id_q, req_id_d;
    logic             fill_valid_q, fill_valid_d;
    logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
    logic [3:0]       fill_way_q, fill_way_d;
    logic [2:0]       fill_op_q, fill_op_d;

    logic             any_free, accept, rsp_hit;
    logic [IDW-1:0]   free_id;

    always_comb begin
        any_free = 1'b0;
        free_id  = '0;
        // Free slot is chosen from the registered view, so a slot freed this cycle waits a cycle
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (st_q[i] == StFree) begin
                any_free = 1'b1;
                free_id  = IDW'(i);
            end
        end
        accept  = req_valid_q & l2_req_ready;
        rsp_hit = l2_rsp_valid && (32'(l2_rsp_id) < N_ENTRIES) && (st_q[l2_rsp_id] == StWait);
    end

    always_comb begin
        st_d         = st_q;
        tag_d        = tag_q;
        wb_tag_d     = wb_tag_q;
        way_d        = way_q;
        op_d         = op_q;
        fill_valid_d = 1'b0;
        fill_tag_d   = fill_tag_q;
        fill_way_d   = fill_way_q;
        fill_op_d    = fill_op_q;
        overflow_d   = overflow_q | (alloc_valid & ~any_free);

        if (accept) begin
            st_d[req_id_q] = (st_q[req_id_q] == StWbReq) ? StRdReq : StWait;
        end
        if (rsp_hit) begin
            st_d[l2_rsp_id] = StFree;
            fill_valid_d    = 1'b1;
            fill_tag_d      = tag_q[l2_rsp_id];
            fill_way_d      = way_q[l2_rsp_id];
            fill_op_d       = op_q[l2_rsp_id];
        end
        if (alloc_valid && any_free) begin
            st_d[free_id]     = alloc_wb ? StWbReq : StRdReq;
            tag_d[free_id]    = alloc_addr[ADDR_W-1:OFF_W];
            wb_tag_d[free_id] = alloc_wb_addr[ADDR_W-1:OFF_W];
            way_d[free_id]    = alloc_way;
            op_d[free_id]     = alloc_op;
        end

        full_d = 1'b1;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (st_d[i] == StFree) full_d = 1'b0;
        end

        req_valid_d = req_valid_q;
        req_wb_d    = req_wb_q;
        req_tag_d   = req_tag_q;
        req_id_d    = req_id_q;
        // A presented request is frozen until accepted; otherwise pick the lowest pending entry
        if (!req_valid_q || accept) begin
            req_valid_d = 1'b0;
            for (int i = N_ENTRIES - 1; i >= 0; i--) begin
                if (st_d[i] == StWbReq || st_d[i] == StRdReq) begin
                    req_valid_d = 1'b1;
                    req_id_d    = IDW'(i);
                    req_wb_d    = (st_d[i] == StWbReq);
                    req_tag_d   = (st_d[i] == StWbReq) ? wb_tag_d[i] : tag_d[i];
                end
            end
        end
    end

    always_comb begin
        mshr_hit = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (st_q[i] != StFree && tag_q[i] == lookup_addr[ADDR_W-1:OFF_W]) mshr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                st_q[i]     <= StFree;
                tag_q[i]    <= '0;
                wb_tag_q[i] <= '0;
                way_q[i]    <= '0;
                op_q[i]     <= '0;
            end
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            req_valid_q  <= 1'b0;
            req_wb_q     <= 1'b0;
            req_tag_q    <= '0;
            req_id_q     <= '0;
            fill_valid_q <= 1'b0;
            fill_tag_q   <= '0;
            fill_way_q   <= '0;
            fill_op_q    <= '0;
        end else begin
            st_q         <= st_d;
            tag_q        <= tag_d;
            wb_tag_q     <= wb_tag_d;
            way_q        <= way_d;
            op_q         <= op_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            req_valid_q  <= req_valid_d;
            req_wb_q     <= req_wb_d;
            req_tag_q    <= req_tag_d;
            req_id_q     <= req_id_d;
            fill_valid_q <= fill_valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_way_q   <= fill_way_d;
            fill_op_q    <= fill_op_d;
        end
    end

    assign full         = full_q;
    assign overflow     = overflow_q;
    assign l2_req_valid = req_valid_q;
    assign l2_req_addr  = {req_tag_q, {OFF_W{1'b0}}};
    assign l2_req_wb    = req_wb_q;
    assign l2_req_id    = req_id_q;
    assign fill_valid   = fill_valid_q;
    assign fill_addr    = {fill_tag_q, {OFF_W{1'b0}}};
    assign fill_way     = fill_way_q;
    assign fill_op      = fill_op_q;
endmodule

// File: tb/tb_cache_mshr.sv
// Directed and randomized bench for cache_mshr, checked against a transaction-level model of
// the outstanding misses.
module tb_cache_mshr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [31:0] alloc_addr = '0;
    logic [3:0]  alloc_way = '0;
    logic [2:0]  alloc_op = '0;
    logic        alloc_wb = 1'b0;
    logic [31:0] alloc_wb_addr = '0;
    logic [31:0] lookup_addr = '0;
    logic        mshr_hit, full, overflow, l2_req_valid, l2_req_wb, fill_valid;
    logic        l2_req_ready = 1'b0;
    logic [31:0] l2_req_addr, fill_addr;
    logic [1:0]  l2_req_id;
    logic        l2_rsp_valid = 1'b0;
    logic [1:0]  l2_rsp_id = '0;
    logic [3:0]  fill_way;
    logic [2:0]  fill_op;

    int checks = 0;
    int failures = 0;
    logic hit_seen;

    cache_mshr #(.N_ENTRIES(4), .ADDR_W(32), .OFF_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_way(alloc_way),
        .alloc_op(alloc_op), .alloc_wb(alloc_wb), .alloc_wb_addr(alloc_wb_addr),
        .lookup_addr(lookup_addr), .mshr_hit(mshr_hit), .full(full), .overflow(overflow),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
        .l2_req_wb(l2_req_wb), .l2_req_id(l2_req_id), .l2_rsp_valid(l2_rsp_valid),
        .l2_rsp_id(l2_rsp_id), .fill_valid(fill_valid), .fill_addr(fill_addr),
        .fill_way(fill_way), .fill_op(fill_op)
    );

    always #5 clk = ~clk;

    // Model: each outstanding miss is busy with a phase (0 = write-back owed, 1 = read owed,
    // 2 = waiting for data); the L2 request slot and fill slot are tracked as expected outputs.
    bit          m_busy [4];
    int          m_ph   [4];
    logic [31:0] m_addr [4];
    logic [31:0] m_wba  [4];
    logic [3:0]  m_way  [4];
    logic [2:0]  m_op   [4];
    bit          e_req_v, e_req_wb, e_fill_v, e_full, e_ovf;
    int          e_req_id;
    logic [31:0] e_req_addr, e_fill_addr;
    logic [3:0]  e_fill_way;
    logic [2:0]  e_fill_op;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'h3f;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        for (int i = 0; i < 4; i++) if (m_busy[i] && line_of(m_addr[i]) == line_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0;
            m_ph[i]   = 0;
        end
        e_req_v = 0; e_req_wb = 0; e_req_id = 0; e_req_addr = '0;
        e_fill_v = 0; e_full = 0; e_ovf = 0;
    endtask

    task automatic model_step();
        int  fi = -1;
        bit  acc = e_req_v && l2_req_ready;
        int  rid = int'(l2_rsp_id);
        for (int i = 0; i < 4; i++) if (!m_busy[i] && fi < 0) fi = i;
        e_fill_v = 0;
        if (l2_rsp_valid && m_busy[rid] && m_ph[rid] == 2) begin
            m_busy[rid] = 0;
            e_fill_v    = 1;
            e_fill_addr = line_of(m_addr[rid]);
            e_fill_way  = m_way[rid];
            e_fill_op   = m_op[rid];
        end
        if (acc) m_ph[e_req_id] = m_ph[e_req_id] + 1;
        if (alloc_valid) begin
            if (fi >= 0) begin
                m_busy[fi] = 1;
                m_ph[fi]   = alloc_wb ? 0 : 1;
                m_addr[fi] = alloc_addr;
                m_wba[fi]  = alloc_wb_addr;
                m_way[fi]  = alloc_way;
                m_op[fi]   = alloc_op;
            end else begin
                e_ovf = 1;
            end
        end
        e_full = m_busy[0] && m_busy[1] && m_busy[2] && m_busy[3];
        if (!e_req_v || acc) begin
            e_req_v = 0;
            for (int i = 3; i >= 0; i--) begin
                if (m_busy[i] && m_ph[i] < 2) begin
                    e_req_v    = 1;
                    e_req_id   = i;
                    e_req_wb   = (m_ph[i] == 0);
                    e_req_addr = (m_ph[i] == 0) ? line_of(m_wba[i]) : line_of(m_addr[i]);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("full", 32'(full), 32'(e_full));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("req_valid", 32'(l2_req_valid), 32'(e_req_v));
        if (e_req_v) begin
            chk("req_addr", l2_req_addr, e_req_addr);
            chk("req_wb", 32'(l2_req_wb), 32'(e_req_wb));
            chk("req_id", 32'(l2_req_id), 32'(e_req_id));
        end
        chk("fill_valid", 32'(fill_valid), 32'(e_fill_v));
        if (e_fill_v) begin
            chk("fill_addr", fill_addr, e_fill_addr);
            chk("fill_way", 32'(fill_way), 32'(e_fill_way));
            chk("fill_op", 32'(fill_op), 32'(e_fill_op));
        end
    endtask

    task automatic tick(input bit av, input logic [31:0] aa, input logic [3:0] aw,
                        input logic [2:0] ao, input bit awb, input logic [31:0] awba,
                        input logic [31:0] lk, input bit rdy, input bit rv, input logic [1:0] rid);
        alloc_valid = av; alloc_addr = aa; alloc_way = aw; alloc_op = ao;
        alloc_wb = awb; alloc_wb_addr = awba; lookup_addr = lk;
        l2_req_ready = rdy; l2_rsp_valid = rv; l2_rsp_id = rid;
        #1;
        hit_seen = mshr_hit;
        chk("mshr_hit", 32'(mshr_hit), 32'(model_hit(lk)));
        @(posedge clk);
        model_step();
        #1;
        chk_all();
    endtask

    task automatic idle(input bit rdy);
        tick(0, '0, '0, '0, 0, '0, '0, rdy, 0, '0);
    endtask

    task automatic rsp(input logic [1:0] id);
        tick(0, '0, '0, '0, 0, '0, '0, 1, 1, id);
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] w, input bit rdy);
        tick(1, a, w, 3'd1, 0, '0, '0, rdy, 0, '0);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all();

        // Clean miss
        ld(32'h1040, 4'b0100, 1);
        chk("t2_req_valid", 32'(l2_req_valid), 32'd1);
        chk("t2_req_addr", l2_req_addr, 32'h1040);
        chk("t2_req_wb", 32'(l2_req_wb), 32'd0);
        chk("t2_req_id", 32'(l2_req_id), 32'd0);
        idle(1);
        rsp(2'd0);
        chk("t2_fill_valid", 32'(fill_valid), 32'd1);
        chk("t2_fill_way", 32'(fill_way), 32'b0100);
        chk("t2_fill_addr", fill_addr, 32'h1040);
        idle(1);
        chk("t2_fill_pulse", 32'(fill_valid), 32'd0);

        // Dirty miss, write-back first, stalled by ready
        tick(1, 32'h2000, 4'b0001, 3'd2, 1, 32'h8000, '0, 0, 0, '0);
        chk("t3_wb_first", 32'(l2_req_wb), 32'd1);
        chk("t3_wb_addr", l2_req_addr, 32'h8000);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("t3_hold_valid", 32'(l2_req_valid), 32'd1);
            chk("t3_hold_addr", l2_req_addr, 32'h8000);
        end
        idle(1);
        chk("t3_rd_valid", 32'(l2_req_valid), 32'd1);
        chk("t3_rd_wb", 32'(l2_req_wb), 32'd0);
        chk("t3_rd_addr", l2_req_addr, 32'h2000);
        idle(1);
        rsp(2'd0);
        chk("t3_fill_op", 32'(fill_op), 32'd2);

        // mshr_hit visibility and offset masking
        tick(1, 32'h3000, 4'b0010, 3'd1, 0, '0, 32'h3000, 1, 0, '0);
        chk("t5_hit_same_cycle", 32'(hit_seen), 32'd0);
        tick(0, '0, '0, '0, 0, '0, 32'h303f, 1, 0, '0);
        chk("t5_hit_offset", 32'(hit_seen), 32'd1);
        tick(0, '0, '0, '0, 0, '0, 32'h3040, 1, 0, '0);
        chk("t5_hit_next_line", 32'(hit_seen), 32'd0);
        rsp(2'd0);
        tick(0, '0, '0, '0, 0, '0, 32'h3000, 1, 0, '0);
        chk("t5_hit_after_fill", 32'(hit_seen), 32'd0);

        // Fill every entry, overflow, then free id 2 and reallocate it
        for (int i = 0; i < 4; i++) ld(32'h4000 + 32'(i) * 32'h40, 4'(1 << i), 1);
        chk("t4_full", 32'(full), 32'd1);
        ld(32'h5000, 4'b1000, 1);
        chk("t4_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) idle(1);
        rsp(2'd2);
        chk("t4_not_full", 32'(full), 32'd0);
        ld(32'h6000, 4'b0001, 0);
        chk("t4_realloc_id", 32'(l2_req_id), 32'd2);
        rsp(2'd0);
        rsp(2'd1);
        rsp(2'd3);
        idle(1);
        idle(1);
        rsp(2'd2);

        // Stray response to a free entry
        rsp(2'd3);
        chk("t6_stray_fill", 32'(fill_valid), 32'd0);

        // Asynchronous reset while an entry waits for data
        ld(32'h7000, 4'b0001, 1);
        idle(1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_req_valid", 32'(l2_req_valid), 32'd0);
        chk("t1_fill_valid", 32'(fill_valid), 32'd0);
        #2 rst_n = 1'b1;
        ld(32'h9000, 4'b0001, 0);
        chk("t1_first_id", 32'(l2_req_id), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a  = 32'h10000 + (32'($urandom_range(0, 7)) << 6) + 32'($urandom_range(0, 63));
            logic [31:0] lk = 32'h10000 + (32'($urandom_range(0, 7)) << 6) + 32'($urandom_range(0, 63));
            logic [31:0] wa = 32'h80000 + (32'($urandom_range(0, 255)) << 6);
            tick($urandom_range(0, 99) < 35, a, 4'(1 << $urandom_range(0, 3)),
                 3'($urandom_range(1, 2)), $urandom_range(0, 1) == 1, wa, lk,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40,
                 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
